// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Pure declarations, no state.
// Access size is derived from one-hot-ish decoder controls.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

  // Byte wins over half over word; no size bit set means doubleword.
  function automatic size_t size_from_ctrl(input logic is_byte, input logic is_half,
                                           input logic is_word);
    size_t sz;
    if (is_byte)      sz = SZ_B;
    else if (is_half) sz = SZ_H;
    else if (is_word) sz = SZ_W;
    else              sz = SZ_D;
    return sz;
  endfunction

  // Byte enables within the 32-bit memory word for one beat.
  function automatic logic [3:0] byte_en(input size_t size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      default: be = 4'hF;
    endcase
    return be;
  endfunction

  // Natural alignment check on the low address bits.
  function automatic logic misaligned(input size_t size, input logic [2:0] a);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = a[0];
      SZ_W:    bad = |a[1:0];
      default: bad = |a[2:0];
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load alignment: shifts the addressed lane down and sign/zero extends it.
// Purely combinational, zero latency.
// No handshake; the caller decides when the result is captured.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [63:0] result
);

  logic [31:0] lane;

  // Select the lane and extend it to 64 bits according to the access size.
  always_comb begin
    lane   = mem_rdata >> {offset, 3'b000};
    result = {32'h0, lane};
    case (size)
      SZ_B:    result = {{56{sign_ext & lane[7]}},  lane[7:0]};
      SZ_H:    result = {{48{sign_ext & lane[15]}}, lane[15:0]};
      SZ_W:    result = {{32{sign_ext & lane[31]}}, lane[31:0]};
      default: result = {32'h0, lane};
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage driving a 32-bit req/gnt/rvalid memory port.
// Latency with zero-wait memory: load 3, store 2, dword load 5, dword store 3, misaligned 1.
// Holds the core via stall until the one-cycle done pulse; waits indefinitely on gnt/rvalid.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_mem,
  input  logic              esc_mem,
  input  logic              byte_mem,
  input  logic              half_mem,
  input  logic              word_mem,
  input  logic              signal_mem,
  input  logic [63:0]       addr,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  state_t            state, state_nx;
  size_t             size_q;
  size_t             req_size;
  logic              sign_q, we_q, beat_q, mis_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base_addr;
  logic [63:0]       wdata_q, rdata_q;
  logic [63:0]       load_val;
  logic              access;
  logic              last_beat;
  logic              unused_addr;

  assign unused_addr = ^addr[63:ADDR_W];
  assign access      = read_mem | esc_mem;
  assign req_size    = size_from_ctrl(byte_mem, half_mem, word_mem);
  // Only a doubleword needs a second beat; beat_q marks the upper word.
  assign last_beat   = (size_q != SZ_D) | beat_q;

  lsu_load_align u_align (
    .mem_rdata (mem_rdata),
    .offset    (addr_q[1:0]),
    .size      (size_q),
    .sign_ext  (sign_q),
    .result    (load_val)
  );

  // State register; reset drops any in-flight access at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: one outstanding request, misaligned accesses skip memory.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (access) state_nx = lsu_pkg::misaligned(req_size, addr[2:0]) ? DONE : REQ;
      REQ:  if (mem_gnt) state_nx = we_q ? (last_beat ? DONE : REQ) : RESP;
      RESP: if (mem_rvalid) state_nx = last_beat ? DONE : REQ;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch the access in IDLE, advance the beat and capture load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= SZ_B;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      beat_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (access) begin
          addr_q  <= addr[ADDR_W-1:0];
          wdata_q <= wdata;
          size_q  <= req_size;
          sign_q  <= signal_mem;
          we_q    <= ~read_mem;
          mis_q   <= lsu_pkg::misaligned(req_size, addr[2:0]);
          beat_q  <= 1'b0;
          rdata_q <= '0;
        end
        REQ: if (mem_gnt && we_q && !last_beat) beat_q <= 1'b1;
        RESP: if (mem_rvalid) begin
          if (size_q == SZ_D) begin
            if (beat_q) rdata_q[63:32] <= mem_rdata;
            else begin
              rdata_q[31:0] <= mem_rdata;
              beat_q        <= 1'b1;
            end
          end else begin
            rdata_q <= load_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign done       = (state == DONE);
  assign misaligned = done & mis_q;
  assign stall      = access & ~done;
  assign rdata      = rdata_q;
  assign mem_req    = (state == REQ);
  assign mem_we     = mem_req & we_q;
  assign base_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_addr   = mem_req ? (base_addr + (beat_q ? ADDR_W'(4) : ADDR_W'(0))) : '0;
  assign mem_be     = mem_req ? byte_en(size_q, addr_q[1:0]) : 4'h0;

  // Store data replicated across lanes so the byte enables pick the bytes.
  always_comb begin
    mem_wdata = 32'h0;
    if (mem_req) begin
      case (size_q)
        SZ_B:    mem_wdata = {4{wdata_q[7:0]}};
        SZ_H:    mem_wdata = {2{wdata_q[15:0]}};
        SZ_W:    mem_wdata = wdata_q[31:0];
        default: mem_wdata = beat_q ? wdata_q[63:32] : wdata_q[31:0];
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan cases plus random accesses.
// A behavioural memory responder with programmable gnt/rvalid delays drives the port.
// Expectations come from size/alignment arithmetic, not from the RTL structure.
module tb_load_store_unit;

  logic        clk, rst_n;
  logic        read_mem, esc_mem, byte_mem, half_mem, word_mem, signal_mem;
  logic [63:0] addr, wdata, rdata;
  logic        done, stall, misaligned;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_mem(read_mem), .esc_mem(esc_mem), .byte_mem(byte_mem),
    .half_mem(half_mem), .word_mem(word_mem), .signal_mem(signal_mem),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .stall(stall),
    .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    read_mem = 0; esc_mem = 0; byte_mem = 0; half_mem = 0; word_mem = 0;
    signal_mem = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h0;
  endtask

  // One access: sz 0=byte 1=half 2=word 3=dword; gd = gnt wait cycles per beat,
  // rvd = extra cycles from gnt to rvalid; stray pulses rvalid while in REQ.
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input int sz, input logic sg,
                            input logic [63:0] a, input logic [63:0] wd,
                            input logic [31:0] lo, input logic [31:0] hi,
                            input int gd, input int rvd, input logic stray,
                            output logic [63:0] got_rdata);
    int          done_cyc, nbeats, wait_g, rv_cnt, stall_bad, stab_bad;
    int          bytes, nb_e, lat_e, off;
    bit          rv_pend, mis_e;
    logic        got_mis;
    logic [31:0] b_addr[2], b_wdata[2], h_addr, h_wdata, lane, w_e;
    logic [3:0]  b_be[2], h_be, be_e;
    logic        b_we[2], h_we;
    logic [63:0] mask, v;

    done_cyc = -1; nbeats = 0; wait_g = 0; rv_cnt = 0; rv_pend = 0;
    stall_bad = 0; stab_bad = 0; got_rdata = '0; got_mis = 0;
    h_addr = '0; h_wdata = '0; h_be = '0; h_we = 0;
    for (int i = 0; i < 2; i++) begin
      b_addr[i] = '0; b_wdata[i] = '0; b_be[i] = '0; b_we[i] = 0;
    end

    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (c == 0) chk({name, "_done_clear_at_start"}, {63'h0, done}, 64'h0);
      read_mem = rd; esc_mem = wr; signal_mem = sg; addr = a; wdata = wd;
      byte_mem = (sz == 0); half_mem = (sz == 1); word_mem = (sz == 2);
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h0;
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1; mem_rdata = (nbeats == 1) ? lo : hi; rv_pend = 0;
        end else rv_cnt--;
      end
      if (mem_req) begin
        if (wait_g == 0) begin
          h_addr = mem_addr; h_be = mem_be; h_wdata = mem_wdata; h_we = mem_we;
        end else if (mem_addr !== h_addr || mem_be !== h_be ||
                     mem_wdata !== h_wdata || mem_we !== h_we) stab_bad++;
        if (wait_g == gd) begin
          mem_gnt = 1;
          if (nbeats < 2) begin
            b_addr[nbeats] = mem_addr; b_be[nbeats] = mem_be;
            b_wdata[nbeats] = mem_wdata; b_we[nbeats] = mem_we;
          end
          nbeats++; wait_g = 0;
          if (!mem_we) begin rv_pend = 1; rv_cnt = rvd; end
        end else wait_g++;
        if (stray && !mem_rvalid) begin mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; end
      end
      #1;
      if (done) begin
        done_cyc = c; got_rdata = rdata; got_mis = misaligned;
        if (stall !== 1'b0) stall_bad++;
      end else if (stall !== 1'b1) stall_bad++;
    end
    idle_inputs();

    // Reference expectations from size/alignment rules.
    bytes = 1 << sz;
    off   = int'(a[1:0]);
    mis_e = (int'(a[2:0]) % bytes) != 0;
    nb_e  = mis_e ? 0 : ((sz == 3) ? 2 : 1);
    lat_e = mis_e ? 1 : (rd ? 1 + nb_e * (2 + gd + rvd) : 1 + nb_e * (1 + gd));

    chk({name, "_latency"}, 64'(done_cyc), 64'(lat_e));
    chk({name, "_misaligned"}, {63'h0, got_mis}, {63'h0, mis_e});
    chk({name, "_beats"}, 64'(nbeats), 64'(nb_e));
    chk({name, "_stall"}, 64'(stall_bad), 64'h0);
    chk({name, "_req_stable"}, 64'(stab_bad), 64'h0);

    for (int i = 0; i < nb_e && i < 2; i++) begin
      be_e = 4'h0;
      for (int j = 0; j < 4; j++)
        be_e[j] = (sz == 3) || (j >= off && j < off + bytes);
      chk($sformatf("%s_b%0d_addr", name, i), {32'h0, b_addr[i]},
          {32'h0, (a[31:0] & 32'hFFFF_FFFC) + 32'(4 * i)});
      chk($sformatf("%s_b%0d_be", name, i), {60'h0, b_be[i]}, {60'h0, be_e});
      chk($sformatf("%s_b%0d_we", name, i), {63'h0, b_we[i]}, {63'h0, !rd});
      if (!rd) begin
        if (sz == 3) w_e = wd[32*i +: 32];
        else for (int j = 0; j < 4; j++) w_e[8*j +: 8] = wd[8*(j % bytes) +: 8];
        chk($sformatf("%s_b%0d_wdata", name, i), {32'h0, b_wdata[i]}, {32'h0, w_e});
      end
    end

    if (mis_e) chk({name, "_rdata_mis"}, got_rdata, 64'h0);
    else if (rd) begin
      if (sz == 3) v = {hi, lo};
      else begin
        lane = lo >> (8 * off);
        mask = (64'h1 << (8 * bytes)) - 64'h1;
        v = {32'h0, lane} & mask;
        if (sg && v[8 * bytes - 1]) v = v | ~mask;
      end
      chk({name, "_rdata"}, got_rdata, v);
    end
  endtask

  initial begin
    logic [63:0] r, ra, rw;
    int          sz;
    logic        rd, wr;

    idle_inputs();
    addr = '0; wdata = '0;
    rst_n = 0;
    #12;
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
    chk("rst_mem_we", {63'h0, mem_we}, 64'h0);
    chk("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
    chk("rst_mem_be", {60'h0, mem_be}, 64'h0);
    chk("rst_mem_wdata", {32'h0, mem_wdata}, 64'h0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_misaligned", {63'h0, misaligned}, 64'h0);
    chk("rst_stall", {63'h0, stall}, 64'h0);
    @(posedge clk); #1 rst_n = 1;

    // Directed plan cases.
    run_access("lb", 1, 0, 0, 1, 64'h1003, 64'h0, 32'h80FF_1234, 32'h0, 0, 0, 0, r);
    chk("lb_value", r, 64'hFFFF_FFFF_FFFF_FF80);
    run_access("lhu", 1, 0, 1, 0, 64'h2002, 64'h0, 32'hBEEF_0000, 32'h0, 0, 0, 0, r);
    chk("lhu_value", r, 64'h0000_0000_0000_BEEF);
    run_access("lwu", 1, 0, 2, 0, 64'h2000, 64'h0, 32'h8000_0001, 32'h0, 0, 0, 0, r);
    chk("lwu_value", r, 64'h0000_0000_8000_0001);
    run_access("lw", 1, 0, 2, 1, 64'h2000, 64'h0, 32'h8000_0001, 32'h0, 0, 0, 0, r);
    run_access("sw", 0, 1, 2, 0, 64'h2010, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 0, r);
    run_access("sd", 0, 1, 3, 0, 64'h3000, 64'h1122_3344_5566_7788, 0, 0, 2, 0, 0, r);
    run_access("sd0", 0, 1, 3, 0, 64'h3008, 64'hA5A5_5A5A_0F0F_F0F0, 0, 0, 0, 0, 0, r);
    run_access("sw_mis", 0, 1, 2, 0, 64'h4002, 64'hFFFF, 0, 0, 0, 0, 0, r);
    run_access("ld", 1, 0, 3, 0, 64'h5000, 64'h0, 32'hAAAA_BBBB, 32'hCCCC_DDDD, 0, 3, 1, r);
    chk("ld_value", r, 64'hCCCC_DDDD_AAAA_BBBB);
    run_access("ld_mis", 1, 0, 3, 1, 64'h5004, 64'h0, 32'h1, 32'h2, 0, 0, 0, r);
    run_access("both", 1, 1, 0, 0, 64'h6001, 64'h77, 32'h0000_9900, 32'h0, 1, 1, 0, r);

    // Random accesses against the reference rules.
    for (int n = 0; n < 40; n++) begin
      sz = $urandom_range(0, 3);
      rd = $urandom_range(0, 1);
      wr = !rd || ($urandom_range(0, 3) == 0);
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) ra[2:0] = ra[2:0] & ~3'((1 << sz) - 1);
      rw = {$urandom, $urandom};
      run_access($sformatf("rnd%0d", n), rd, wr, sz, 1'($urandom_range(0, 1)), ra, rw,
                 $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), r);
    end

    // Reset while a load waits in RESP.
    @(posedge clk); #1;
    read_mem = 1; word_mem = 1; addr = 64'h7000;
    @(posedge clk); #1;
    chk("rstmid_req_seen", {63'h0, mem_req}, 64'h1);
    mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    chk("rstmid_req_after_gnt", {63'h0, mem_req}, 64'h0);
    #2 rst_n = 0;
    #1;
    chk("rstmid_mem_req", {63'h0, mem_req}, 64'h0);
    chk("rstmid_done", {63'h0, done}, 64'h0);
    chk("rstmid_rdata", rdata, 64'h0);
    chk("rstmid_mem_be", {60'h0, mem_be}, 64'h0);
    idle_inputs();
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("rstmid_no_done%0d", c), {63'h0, done}, 64'h0);
      chk($sformatf("rstmid_no_req%0d", c), {63'h0, mem_req}, 64'h0);
      @(posedge clk); #1;
      mem_rvalid = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage downstream of the control decoder.
- Consumes the decoder's memory controls (read_mem, esc_mem, byte_mem, half_mem, word_mem, signal_mem) plus the ALU-computed address and the rs2 store data.
- Drives a 32-bit request/grant/response data-memory port and returns a sign- or zero-extended 64-bit load result.
- Stalls the core while an access is in flight.

Parameters:
- ADDR_W, 32, width of mem_addr; addr[ADDR_W-1:0] is used, upper bits ignored.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- read_mem  in  1  load request (held stable by core while stall=1)
- esc_mem  in  1  store request (held stable by core while stall=1)
- byte_mem  in  1  size = byte
- half_mem  in  1  size = half
- word_mem  in  1  size = word; none of byte/half/word set = doubleword
- signal_mem  in  1  loads: 1 = sign-extend, 0 = zero-extend; ignored for stores
- addr  in  64  effective address
- wdata  in  64  store data
- rdata  out  64  load result, valid while done=1
- done  out  1  one-cycle completion pulse
- stall  out  1  core must hold PC and inputs
- misaligned  out  1  valid with done; access was suppressed
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  write data, lane-replicated
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid (reads only)
- mem_rdata  in  32  read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset: state IDLE. rdata, done, misaligned, mem_req, mem_we, mem_addr, mem_be and mem_wdata are all 0. Reset mid-access drops mem_req immediately and discards the access; any late mem_gnt/mem_rvalid is ignored.
- Stall: stall = (read_mem | esc_mem) & ~done, combinational.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If read_mem|esc_mem, latch addr, wdata, size, signal and direction; read_mem has priority if both are set.
  - Misaligned check: half with addr[0]=1, word with addr[1:0]≠0, dword with addr[2:0]≠0. If misaligned, go to DONE with misaligned=1, rdata=0, and issue no mem_req.
  - Otherwise go to REQ with beat=0.
- REQ:
  - mem_req=1 with payload held stable until mem_gnt.
  - Store: on gnt, go to DONE, or REQ beat 1 for dword beat 0.
  - Load: on gnt, go to RESP.
  - mem_req is low in the cycle after gnt (one outstanding request max).
- RESP:
  - Wait for mem_rvalid; capture mem_rdata into the lo/hi half by beat.
  - Dword beat 0: go to REQ with beat=1. Otherwise go to DONE.
  - mem_rvalid outside RESP is ignored.
- DONE:
  - done=1 for exactly one cycle, stall=0; the core commits at this edge.
  - Then IDLE. A request present in the following IDLE cycle is a new access.
- Address: mem_addr = {addr[ADDR_W-1:2],2'b00}, plus 4 on dword beat 1.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word and dword beats: 4'hF
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata[31:0]
  - dword: beat 0 = wdata[31:0], beat 1 = wdata[63:32]
- Load data:
  - Lane = mem_rdata >> (8*addr[1:0]).
  - byte/half/word take lane[7:0]/[15:0]/[31:0], extended to 64 bits per signal_mem.
  - dword returns {hi,lo}; signal_mem is irrelevant.
- Latency:
  - Zero-wait memory (gnt same cycle, rvalid next cycle): word load 3 cycles to done, store 2, dword load 5, dword store 3, misaligned 1.

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE, REQ, RESP, DONE}
  - size enum {SZ_B, SZ_H, SZ_W, SZ_D}
  - functions size_from_ctrl(byte,half,word), byte_en(size,off), misaligned(size,addr[2:0])
- Sub-module lsu_load_align: combinational lane shift plus sign/zero extension (inputs: mem_rdata, offset, size, signed; output: 64-bit).

Test Plan:
- LB signed: addr=0x1003, mem_rdata=0x80FF_1234, zero-wait → mem_be=0000_1000 (4'b1000), rdata=0xFFFF_FFFF_FFFF_FF80, done 3 cycles after request.
- LHU/LWU zero-extend: LHU at addr=0x2002 with mem_rdata=0xBEEF_0000 → rdata=0x0000_0000_0000_BEEF. LWU at 0x2000 with 0x8000_0001 → rdata=0x0000_0000_8000_0001.
- SD at 0x3000, wdata=0x1122_3344_5566_7788, gnt delayed 2 cycles per beat:
  - Beat 0: addr 0x3000, data 0x5566_7788, be F.
  - Beat 1: addr 0x3004, data 0x1122_3344.
  - stall stays high until done; mem_req held stable across waits.
- Misaligned SW at addr=0x4002 → no mem_req ever, done=1 and misaligned=1 in the cycle after request, rdata=0.
- LD at 0x5000 with rvalid delayed 3 cycles per beat: lo=0xAAAA_BBBB, hi=0xCCCC_DDDD → rdata=0xCCCC_DDDD_AAAA_BBBB; a stray mem_rvalid pulse in REQ is ignored.
- Async reset asserted in RESP of a load → mem_req, done, stall-source state and rdata clear immediately; after release, a mem_rvalid arriving in IDLE produces no done.
